// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU long-arithmetic sequencer.
package xc_malu_pkg;

  // Shift-add iterations in the multiply phase (RV32).
  localparam int MUL_STEPS = 32;

  // Width of the accumulator and of the returned result.
  localparam int RESULT_W = 64;

  // Sequencer state encoding; IDLE must stay at zero.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MDR    = 3'd1,
    ST_MSUB_1 = 3'd2,
    ST_MACC_1 = 3'd3,
    ST_MMUL_2 = 3'd4,
    ST_MMUL_1 = 3'd5,
    ST_DONE   = 3'd6
  } malu_state_t;

endpackage

// File: rtl/xc_malu_mdr_step.sv
// One radix-2 shift-add multiply step: conditionally add rs1 into the
// high word, then shift the whole accumulator right by one.
module xc_malu_mdr_step
  import xc_malu_pkg::*;
(
  input  logic [RESULT_W-1:0] acc,
  input  logic [31:0]         rs1,
  output logic [RESULT_W-1:0] n_acc
);

  logic [32:0] sum;

  // 33-bit add keeps the carry so it lands in acc[63] after the shift.
  always_comb begin
    sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? rs1 : 32'd0)};
    n_acc = {sum, acc[31:1]};
  end

endmodule

// File: rtl/xc_malu_long_seq.sv
// Sequencer and state registers in front of the MALU long-arithmetic
// datapath. Runs the multiply phase locally with a shift-add loop.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   IDLE      | waiting for valid; madd completes here in 1 cycle
//   MDR       | shift-add multiply step, count 0..MUL_STEPS-1
//   MSUB_1    | second msub step (subtract rs3)
//   MACC_1    | second macc step (propagate carry into high word)
//   MMUL_2    | add rs3 into the low word of the product
//   MMUL_1    | propagate carry into the high word
//   DONE      | ready for one cycle, then back to IDLE
module xc_malu_long_seq
  import xc_malu_pkg::*;
(
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                valid,
  input  logic                flush,
  input  logic [31:0]         rs1,
  input  logic [31:0]         rs2,
  input  logic [31:0]         rs3,
  input  logic                uop_madd,
  input  logic                uop_msub,
  input  logic                uop_macc,
  input  logic                uop_mmul,
  output logic                fsm_init,
  output logic                fsm_mdr,
  output logic                fsm_msub_1,
  output logic                fsm_macc_1,
  output logic                fsm_mmul_1,
  output logic                fsm_mmul_2,
  output logic                fsm_done,
  output logic [RESULT_W-1:0] acc,
  output logic                carry,
  output logic [5:0]          count,
  input  logic [RESULT_W-1:0] dp_n_acc,
  input  logic                dp_n_carry,
  input  logic [RESULT_W-1:0] dp_result,
  input  logic                dp_ready,
  output logic                ready,
  output logic [RESULT_W-1:0] result
);

  malu_state_t         state_q, state_d;
  logic [RESULT_W-1:0] acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [5:0]          count_q, count_d;
  logic [RESULT_W-1:0] mdr_n_acc;

  // rs3 is consumed only by the external datapath.
  logic unused_rs3;
  assign unused_rs3 = ^rs3;

  xc_malu_mdr_step u_mdr_step (
    .acc   (acc_q),
    .rs1   (rs1),
    .n_acc (mdr_n_acc)
  );

  // Step strobes are pure state decodes, kept apart from the next-state
  // logic so the datapath feedback path stays acyclic.
  assign fsm_init   = valid && (state_q == ST_IDLE);
  assign fsm_mdr    = (state_q == ST_MDR);
  assign fsm_msub_1 = (state_q == ST_MSUB_1);
  assign fsm_macc_1 = (state_q == ST_MACC_1);
  assign fsm_mmul_2 = (state_q == ST_MMUL_2);
  assign fsm_mmul_1 = (state_q == ST_MMUL_1);
  assign fsm_done   = (state_q == ST_DONE);

  assign acc   = acc_q;
  assign carry = carry_q;
  assign count = count_q;

  // Completion handshake; madd bypasses the registers entirely.
  always_comb begin
    ready  = 1'b0;
    result = acc_q;
    if (state_q == ST_IDLE && valid && uop_madd) begin
      ready  = dp_ready;
      result = dp_result;
    end else if (state_q == ST_DONE) begin
      ready = 1'b1;
    end
    if (flush) ready = 1'b0;
  end

  // Next-state and register-update decode; flush overrides everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (uop_msub) begin
            acc_d   = dp_n_acc;
            state_d = ST_MSUB_1;
          end else if (uop_macc) begin
            acc_d   = dp_n_acc;
            carry_d = dp_n_carry;
            state_d = ST_MACC_1;
          end else if (uop_mmul) begin
            acc_d   = {32'd0, rs2};
            count_d = 6'd0;
            state_d = ST_MDR;
          end
        end
      end
      ST_MDR: begin
        acc_d   = mdr_n_acc;
        count_d = count_q + 6'd1;
        if (count_q == 6'(MUL_STEPS - 1)) state_d = ST_MMUL_2;
      end
      ST_MMUL_2: begin
        acc_d   = dp_n_acc;
        carry_d = dp_n_carry;
        state_d = ST_MMUL_1;
      end
      ST_MMUL_1: begin
        acc_d   = dp_n_acc;
        state_d = ST_DONE;
      end
      ST_MSUB_1: begin
        acc_d   = dp_n_acc;
        state_d = ST_DONE;
      end
      ST_MACC_1: begin
        acc_d   = dp_n_acc;
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      carry_d = 1'b0;
      count_d = 6'd0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

endmodule
